// File: rtl/ysyx_25060170_regfile_pkg.sv
// Shared defaults and constants for the integer register file and its scoreboard.
package ysyx_25060170_regfile_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned NR_REGS_DEF = 32;
    localparam int unsigned AW_DEF      = $clog2(NR_REGS_DEF);

    localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_LAST  = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd3;

endpackage

// File: rtl/ysyx_25060170_scoreboard.sv
// Pending-write counters per architectural register, sticky underflow flag and
// the decode stall decision.
module ysyx_25060170_scoreboard
    import ysyx_25060170_regfile_pkg::*;
#(
    parameter int unsigned NR_REGS = NR_REGS_DEF,
    parameter int unsigned AW      = $clog2(NR_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_rd_ena,
    input  logic [AW-1:0] wb_rd_addr,
    input  logic          ie_flush,
    input  logic          id_issue,
    input  logic          id_rd_ena,
    input  logic [AW-1:0] id_rd_addr,
    input  logic          rs1_ena,
    input  logic [AW-1:0] rs1_addr,
    input  logic          rs2_ena,
    input  logic [AW-1:0] rs2_addr,
    output logic          id_stall,
    output logic          sb_err
);

    logic [1:0] cnt_q [NR_REGS];
    logic [1:0] cnt_d [NR_REGS];
    logic       sb_err_q, sb_err_d;
    logic       inc, dec, same, hazard1, hazard2, full;

    assign inc  = id_issue & ~id_stall & id_rd_ena & (id_rd_addr != '0);
    assign dec  = wb_rd_ena & (wb_rd_addr != '0);
    assign same = inc & dec & (id_rd_addr == wb_rd_addr);

    // The last outstanding write landing this cycle is served by the bypass.
    assign hazard1 = rs1_ena & (cnt_q[rs1_addr] != CNT_EMPTY)
                   & ~(dec & (wb_rd_addr == rs1_addr) & (cnt_q[rs1_addr] == CNT_LAST));
    assign hazard2 = rs2_ena & (cnt_q[rs2_addr] != CNT_EMPTY)
                   & ~(dec & (wb_rd_addr == rs2_addr) & (cnt_q[rs2_addr] == CNT_LAST));
    assign full    = id_rd_ena & (cnt_q[id_rd_addr] == CNT_FULL);

    assign id_stall = hazard1 | hazard2 | full;
    assign sb_err   = sb_err_q;

    always_comb begin
        sb_err_d = sb_err_q;
        cnt_d    = cnt_q;
        if (ie_flush) begin
            for (int i = 0; i < NR_REGS; i++) begin
                cnt_d[i] = CNT_EMPTY;
            end
        end else if (!same) begin
            if (inc) begin
                cnt_d[id_rd_addr] = cnt_q[id_rd_addr] + 2'd1;
            end
            if (dec) begin
                if (cnt_q[wb_rd_addr] == CNT_EMPTY) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[wb_rd_addr] = cnt_q[wb_rd_addr] - 2'd1;
                end
            end
        end
        cnt_d[0] = CNT_EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR_REGS; i++) begin
                cnt_q[i] <= CNT_EMPTY;
            end
            sb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

endmodule

// File: rtl/ysyx_25060170_regfile.sv
// Architectural register file: storage, write-back port, bypassed read ports and
// the pending-write scoreboard that drives the decode stall.
module ysyx_25060170_regfile
    import ysyx_25060170_regfile_pkg::*;
#(
    parameter int unsigned NR_REGS = NR_REGS_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned AW      = $clog2(NR_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_rd_ena,
    input  logic [AW-1:0]     wb_rd_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ie_flush,
    input  logic              id_issue,
    input  logic              id_rd_ena,
    input  logic [AW-1:0]     id_rd_addr,
    input  logic              rs1_ena,
    input  logic [AW-1:0]     rs1_addr,
    input  logic              rs2_ena,
    input  logic [AW-1:0]     rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              id_stall,
    output logic              sb_err
);

    localparam logic [DATA_W-1:0] Zero = DATA_W'(ZERO_WORD);

    logic [DATA_W-1:0] regs_q [NR_REGS];
    logic [DATA_W-1:0] regs_d [NR_REGS];
    logic              wr_en;

    assign wr_en = wb_rd_ena & (wb_rd_addr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wb_rd_addr] = wb_data;
        end
        regs_d[0] = Zero;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR_REGS; i++) begin
                regs_q[i] <= Zero;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rs1_data = regs_q[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = Zero;
        end else if (wr_en && (wb_rd_addr == rs1_addr)) begin
            rs1_data = wb_data;
        end
    end

    always_comb begin
        rs2_data = regs_q[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = Zero;
        end else if (wr_en && (wb_rd_addr == rs2_addr)) begin
            rs2_data = wb_data;
        end
    end

    ysyx_25060170_scoreboard #(
        .NR_REGS(NR_REGS),
        .AW     (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wb_rd_ena (wb_rd_ena),
        .wb_rd_addr(wb_rd_addr),
        .ie_flush  (ie_flush),
        .id_issue  (id_issue),
        .id_rd_ena (id_rd_ena),
        .id_rd_addr(id_rd_addr),
        .rs1_ena   (rs1_ena),
        .rs1_addr  (rs1_addr),
        .rs2_ena   (rs2_ena),
        .rs2_addr  (rs2_addr),
        .id_stall  (id_stall),
        .sb_err    (sb_err)
    );

endmodule

// File: tb/tb_ysyx_25060170_regfile.sv
// Directed and random checks of the register file against a reference model of
// register values and outstanding-write counts.
module tb_ysyx_25060170_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_rd_ena;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        ie_flush;
    logic        id_issue;
    logic        id_rd_ena;
    logic [4:0]  id_rd_addr;
    logic        rs1_ena;
    logic [4:0]  rs1_addr;
    logic        rs2_ena;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        id_stall;
    logic        sb_err;

    int          errors = 0;
    int          checks = 0;

    // Reference model
    logic [31:0] m_mem [32];
    int          m_cnt [32];
    bit          m_err;

    ysyx_25060170_regfile u_dut (
        .clk       (clk),
        .rst       (rst),
        .wb_rd_ena (wb_rd_ena),
        .wb_rd_addr(wb_rd_addr),
        .wb_data   (wb_data),
        .ie_flush  (ie_flush),
        .id_issue  (id_issue),
        .id_rd_ena (id_rd_ena),
        .id_rd_addr(id_rd_addr),
        .rs1_ena   (rs1_ena),
        .rs1_addr  (rs1_addr),
        .rs2_ena   (rs2_ena),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .id_stall  (id_stall),
        .sb_err    (sb_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = '0;
            m_cnt[i] = 0;
        end
        m_err = 1'b0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_rd_ena && wb_rd_addr == a) return wb_data;
        return m_mem[a];
    endfunction

    function automatic bit exp_hazard(input logic en, input logic [4:0] a);
        bit landing_last;
        landing_last = wb_rd_ena && (wb_rd_addr == a) && (a != 0) && (m_cnt[a] == 1);
        return en && (m_cnt[a] != 0) && !landing_last;
    endfunction

    function automatic bit exp_stall();
        return exp_hazard(rs1_ena, rs1_addr) || exp_hazard(rs2_ena, rs2_addr)
            || (id_rd_ena && m_cnt[id_rd_addr] == 3);
    endfunction

    function automatic void model_edge(input bit stall);
        bit inc, dec;
        inc = id_issue && !stall && id_rd_ena && id_rd_addr != 0;
        dec = wb_rd_ena && wb_rd_addr != 0;
        if (dec) m_mem[wb_rd_addr] = wb_data;
        if (ie_flush) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        end else if (!(inc && dec && id_rd_addr == wb_rd_addr)) begin
            if (inc) m_cnt[id_rd_addr]++;
            if (dec) begin
                if (m_cnt[wb_rd_addr] == 0) m_err = 1'b1;
                else m_cnt[wb_rd_addr]--;
            end
        end
    endfunction

    task automatic clear_inputs();
        wb_rd_ena = 0; wb_rd_addr = 0; wb_data = 0; ie_flush = 0;
        id_issue = 0; id_rd_ena = 0; id_rd_addr = 0;
        rs1_ena = 0; rs1_addr = 0; rs2_ena = 0; rs2_addr = 0;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic cycle(input string tag);
        bit s;
        #1;
        s = exp_stall();
        check_eq({tag, ".rs1"}, rs1_data, exp_rd(rs1_addr));
        check_eq({tag, ".rs2"}, rs2_data, exp_rd(rs2_addr));
        check_eq({tag, ".stall"}, {31'b0, id_stall}, {31'b0, s});
        check_eq({tag, ".err"}, {31'b0, sb_err}, {31'b0, m_err});
        @(posedge clk);
        model_edge(s);
        @(negedge clk);
    endtask

    task automatic issue(input logic [4:0] rd, input string tag);
        clear_inputs();
        id_issue = 1; id_rd_ena = 1; id_rd_addr = rd;
        cycle(tag);
    endtask

    initial begin
        int q[$];
        clear_inputs();
        model_reset();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rs1_ena = 1; rs1_addr = 5'd5; rs2_ena = 1; rs2_addr = 5'd31;
        #1;
        check_eq("reset.rs1", rs1_data, 32'h0);
        check_eq("reset.rs2", rs2_data, 32'h0);
        check_eq("reset.stall", {31'b0, id_stall}, 32'h0);
        check_eq("reset.err", {31'b0, sb_err}, 32'h0);
        @(negedge clk);
        rst = 0;
        clear_inputs();

        // Write then read
        wb_rd_ena = 1; wb_rd_addr = 5'd5; wb_data = 32'h1234_5678;
        cycle("wr5");
        clear_inputs();
        rs1_ena = 1; rs1_addr = 5'd5;
        #1;
        check_eq("x5.read", rs1_data, 32'h1234_5678);
        check_eq("x5.nostall", {31'b0, id_stall}, 32'h0);
        cycle("rd5");

        // x0 rule
        clear_inputs();
        wb_rd_ena = 1; wb_rd_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        rs2_ena = 1; rs2_addr = 5'd0;
        cycle("wr0");
        issue(5'd0, "iss0");
        clear_inputs();
        rs1_ena = 1; rs1_addr = 5'd0; rs2_ena = 1; rs2_addr = 5'd0;
        #1;
        check_eq("x0.read", rs2_data, 32'h0);
        check_eq("x0.nostall", {31'b0, id_stall}, 32'h0);
        cycle("rd0");

        // Issue then dependent
        issue(5'd7, "iss7");
        clear_inputs();
        rs1_ena = 1; rs1_addr = 5'd7;
        #1;
        check_eq("dep7.stall", {31'b0, id_stall}, 32'h1);
        cycle("dep7a");
        cycle("dep7b");
        wb_rd_ena = 1; wb_rd_addr = 5'd7; wb_data = 32'hA5;
        #1;
        check_eq("dep7.bypass", rs1_data, 32'hA5);
        check_eq("dep7.release", {31'b0, id_stall}, 32'h0);
        cycle("wb7");

        // Double pending
        issue(5'd3, "iss3a");
        issue(5'd3, "iss3b");
        clear_inputs();
        rs1_ena = 1; rs1_addr = 5'd3;
        wb_rd_ena = 1; wb_rd_addr = 5'd3; wb_data = 32'd1;
        #1;
        check_eq("dbl.hold", {31'b0, id_stall}, 32'h1);
        cycle("wb3a");
        wb_rd_ena = 0;
        cycle("dbl.gap");
        wb_rd_ena = 1; wb_data = 32'd2;
        #1;
        check_eq("dbl.release", {31'b0, id_stall}, 32'h0);
        check_eq("dbl.data", rs1_data, 32'd2);
        cycle("wb3b");

        // Full and underflow
        issue(5'd9, "iss9a");
        issue(5'd9, "iss9b");
        issue(5'd9, "iss9c");
        clear_inputs();
        id_issue = 1; id_rd_ena = 1; id_rd_addr = 5'd9;
        #1;
        check_eq("full.stall", {31'b0, id_stall}, 32'h1);
        cycle("iss9d");
        clear_inputs();
        wb_rd_ena = 1; wb_rd_addr = 5'd10; wb_data = 32'h77;
        cycle("uflow");
        clear_inputs();
        #1;
        check_eq("uflow.err", {31'b0, sb_err}, 32'h1);
        cycle("uflow.hold1");
        cycle("uflow.hold2");

        // Flush
        issue(5'd4, "iss4");
        issue(5'd6, "iss6");
        clear_inputs();
        ie_flush = 1; wb_rd_ena = 1; wb_rd_addr = 5'd4; wb_data = 32'h55;
        cycle("flush");
        clear_inputs();
        rs1_ena = 1; rs1_addr = 5'd6; rs2_ena = 1; rs2_addr = 5'd4;
        #1;
        check_eq("flush.nostall", {31'b0, id_stall}, 32'h0);
        check_eq("flush.x4", rs2_data, 32'h55);
        cycle("post.flush");

        // Async reset between edges
        clear_inputs();
        rs1_ena = 1; rs1_addr = 5'd5; rs2_ena = 1; rs2_addr = 5'd4;
        #2;
        rst = 1;
        #1;
        check_eq("areset.rs1", rs1_data, 32'h0);
        check_eq("areset.rs2", rs2_data, 32'h0);
        check_eq("areset.err", {31'b0, sb_err}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 0;

        // Random traffic; write-backs only retire outstanding writes (or target x0)
        for (int n = 0; n < 3000; n++) begin
            clear_inputs();
            q.delete();
            for (int i = 1; i < 32; i++) if (m_cnt[i] > 0) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                wb_rd_ena  = 1;
                wb_rd_addr = 5'(q[$urandom_range(0, q.size() - 1)]);
            end else if ($urandom_range(0, 7) == 0) begin
                wb_rd_ena  = 1;
                wb_rd_addr = 5'd0;
            end
            wb_data    = $urandom;
            ie_flush   = ($urandom_range(0, 39) == 0);
            id_issue   = 1'($urandom_range(0, 1));
            id_rd_ena  = 1'($urandom_range(0, 1));
            id_rd_addr = 5'($urandom_range(0, 7));
            rs1_ena    = 1'($urandom_range(0, 1));
            rs1_addr   = 5'($urandom_range(0, 9));
            rs2_ena    = 1'($urandom_range(0, 1));
            rs2_addr   = 5'($urandom_range(0, 31));
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_25060170_regfile.md
# ysyx_25060170_regfile

Architectural integer register file with a pending-write scoreboard. It receives the write-back stream produced at the end of the pipeline and serves the two combinational source-operand read ports of the decode stage. It tracks in-flight destination registers and raises the decode stall when an operand is not yet available. It sits between the write-back unit (writer) and the decode unit (reader and issuer).

## Interface
Parameters:
- NR_REGS, 32: number of architectural registers. Must be 16 or 32.
- DATA_W, 32: register width.
- AW, $clog2(NR_REGS): register address width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wb_rd_ena  in  1  write-back write enable.
- wb_rd_addr  in  AW  write-back destination register.
- wb_data  in  DATA_W  write-back data.
- ie_flush  in  1  trap/interrupt flush; squashes all younger in-flight instructions.
- id_issue  in  1  decode issues an instruction this cycle. Only honoured when id_stall=0.
- id_rd_ena  in  1  the issued instruction writes a register.
- id_rd_addr  in  AW  destination register of the issued instruction.
- rs1_ena / rs2_ena  in  1  source operand is used.
- rs1_addr / rs2_addr  in  AW  source register address.
- rs1_data / rs2_data  out  DATA_W  operand value (combinational).
- id_stall  out  1  decode must hold (combinational).
- sb_err  out  1  sticky scoreboard underflow flag.

## Operation
- **Storage:** NR_REGS×DATA_W flops.
  - Register 0 always reads 0.
  - Writes to register 0 are dropped.
- **Write:** when wb_rd_ena=1 and wb_rd_addr≠0, the register is written with wb_data at the clock edge.
- **Read with bypass:** rsN_data = 0 if rsN_addr=0. Otherwise it equals wb_data when wb_rd_ena=1 and wb_rd_addr=rsN_addr. Otherwise it equals the stored value.
- **Scoreboard:** one 2-bit pending counter per register. Register 0 has no counter and is never pending.
  - inc = id_issue & ~id_stall & id_rd_ena & (id_rd_addr≠0)
  - dec = wb_rd_ena & (wb_rd_addr≠0)
  - If inc and dec target the same register in the same cycle, that counter is unchanged.
  - dec on a counter already at 0: the counter stays at 0 and sb_err is set. sb_err clears only on rst.
- **Stall:** id_stall = hazard(rs1) | hazard(rs2) | full.
  - hazard(N) = rsN_ena & cnt[rsN_addr]≠0 & ~(dec to rsN_addr & cnt[rsN_addr]=1). A last pending write arriving this cycle is bypassed, not stalled.
  - full = id_rd_ena & cnt[id_rd_addr]=3. This prevents counter overflow.
- **Flush:** ie_flush=1 clears all counters at the edge, overriding inc and dec.
  - The write-back data write in the same cycle still occurs.
  - No underflow check is made in a flush cycle.

## Timing
- **Reset:** all registers 0, all counters 0, sb_err=0, asynchronously. Outputs are then rs1_data=rs2_data=0 and id_stall=0, unless an operand is requested from a register with pending writes (none after reset).
- **Latency:**
  - Reads and stall: 0 cycles.
  - Write: visible in storage from the cycle after the edge; visible via bypass in the same cycle.
- **Counter updates** take effect at the edge, so id_stall reflects them from the next cycle.
- **rst mid-operation** discards all pending state immediately. No write is performed during reset.

## Structure
- **Shared define/package:** DATA_W and NR_REGS defaults, and the zero constant. Use the existing project data, register-address and zero macros.
- **Sub-module ysyx_25060170_scoreboard:** holds the counters, sb_err and the stall logic.
- **Top:** holds the storage array, the write port and the bypass muxes.

## Test plan
- **Write then read:** write x5=0x12345678. Next cycle, rs1_addr=5 → rs1_data=0x12345678, id_stall=0.
- **x0 rule:** write x0=0xFFFFFFFF → rs2_addr=0 reads 0. Issue with rd=0 → no counter change and no stall.
- **Issue then dependent:** issue rd=7, then rs1_addr=7 with rs1_ena=1 → id_stall=1 until write-back x7=0xA5. In the write-back cycle, id_stall=0 and rs1_data=0xA5 via bypass.
- **Double pending:** issue rd=3 twice, then one write-back x3=1. Stall is held; it releases only on the second write-back, x3=2, with rs1_data=2.
- **Full and underflow:**
  - Three issues to rd=9, then a fourth attempted → id_stall=1.
  - Write-back x10 with cnt[10]=0 → sb_err=1, and it stays 1 until rst.
- **Flush and async reset:**
  - Issue rd=4 and rd=6, then ie_flush=1 with write-back x4=0x55 → all counters 0, x4=0x55, rs on 6 no longer stalls.
  - Assert rst between edges → storage reads 0 immediately.
